// File: rtl/stack_seq_pkg.sv
// Shared encodings for the stack sequencer: command codes, FSM states and depth limit.
package stack_seq_pkg;

    localparam logic [7:0] DEPTH_MAX = 8'd255;

    typedef enum logic [2:0] {
        CMD_PUSH8  = 3'b000,
        CMD_POP8   = 3'b001,
        CMD_PUSH16 = 3'b010,
        CMD_POP16  = 3'b011,
        CMD_LOAD   = 3'b100
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DEC  = 3'd1,
        ST_WR   = 3'd2,
        ST_RD   = 3'd3,
        ST_INC  = 3'd4,
        ST_LD   = 3'd5
    } state_e;

    // Number of bytes moved by a push/pop command; zero for anything else.
    function automatic logic [1:0] cmd_bytes(input logic [2:0] cmd);
        logic [1:0] nbytes;
        case (cmd)
            CMD_PUSH8, CMD_POP8:   nbytes = 2'd1;
            CMD_PUSH16, CMD_POP16: nbytes = 2'd2;
            default:               nbytes = 2'd0;
        endcase
        return nbytes;
    endfunction

    function automatic logic cmd_is_push(input logic [2:0] cmd);
        return (cmd == CMD_PUSH8) || (cmd == CMD_PUSH16);
    endfunction

    function automatic logic cmd_is_pop(input logic [2:0] cmd);
        return (cmd == CMD_POP8) || (cmd == CMD_POP16);
    endfunction

endpackage

// File: rtl/stack_depth_counter.sv
// Byte-depth up/down counter with a combinational check of whether a requested
// push or pop of 1-2 bytes would stay inside 0..DEPTH_MAX.
module stack_depth_counter
    import stack_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       count_up,
    input  logic       count_down,
    input  logic       clear,
    input  logic       check_push,
    input  logic [1:0] check_bytes,
    output logic [7:0] depth,
    output logic       check_ok
);

    logic [7:0] depth_q;
    logic [7:0] depth_d;
    logic [8:0] push_sum;

    always_comb begin
        depth_d = depth_q;
        if (clear) begin
            depth_d = 8'd0;
        end else if (count_up) begin
            depth_d = depth_q + 8'd1;
        end else if (count_down) begin
            depth_d = depth_q - 8'd1;
        end
    end

    // The sum is one bit wider so that 254 + 2 is seen as overflow, not as 0.
    always_comb begin
        push_sum = {1'b0, depth_q} + {7'b0, check_bytes};
        if (check_push) begin
            check_ok = (push_sum <= {1'b0, DEPTH_MAX});
        end else begin
            check_ok = (depth_q >= {6'b0, check_bytes});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= 8'd0;
        end else begin
            depth_q <= depth_d;
        end
    end

    assign depth = depth_q;

endmodule

// File: rtl/stack_sequencer.sv
// Stack-pointer/memory strobe sequencer: turns PUSH/POP/LOAD commands into
// one-cycle-per-step strobe sequences, with all outputs registered.
module stack_sequencer
    import stack_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] cmd,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       sp_outn,
    output logic       sp_loadn,
    output logic       sp_cupn,
    output logic       sp_cdownn,
    output logic       mem_oen,
    output logic       mem_wen,
    output logic       byte_sel,
    output logic [7:0] depth
);

    state_e state_q, state_d;
    logic   second_q, second_d;
    logic   is16_q, is16_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   err_q, err_d;
    logic   byte_sel_q, byte_sel_d;
    logic   sp_outn_q, sp_outn_d;
    logic   sp_loadn_q, sp_loadn_d;
    logic   sp_cupn_q, sp_cupn_d;
    logic   sp_cdownn_q, sp_cdownn_d;
    logic   mem_oen_q, mem_oen_d;
    logic   mem_wen_q, mem_wen_d;

    logic   check_ok;
    logic   check_push;
    logic   [1:0] check_bytes;

    assign check_push  = cmd_is_push(cmd);
    assign check_bytes = cmd_bytes(cmd);

    // Depth moves on the edge that ends each DEC/INC, and clears as LD ends.
    stack_depth_counter u_depth (
        .clk         (clk),
        .reset       (reset),
        .count_up    (state_q == ST_DEC),
        .count_down  (state_q == ST_INC),
        .clear       (state_q == ST_LD),
        .check_push  (check_push),
        .check_bytes (check_bytes),
        .depth       (depth),
        .check_ok    (check_ok)
    );

    always_comb begin
        state_d  = state_q;
        second_d = second_q;
        is16_d   = is16_q;
        err_d    = err_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    second_d = 1'b0;
                    is16_d   = cmd[1];
                    if (cmd == CMD_LOAD) begin
                        state_d = ST_LD;
                    end else if (cmd_is_push(cmd) && check_ok) begin
                        state_d = ST_DEC;
                    end else if (cmd_is_pop(cmd) && check_ok) begin
                        state_d = ST_RD;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            ST_DEC: state_d = ST_WR;
            ST_WR: begin
                if (is16_q && !second_q) begin
                    state_d  = ST_DEC;
                    second_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_RD: state_d = ST_INC;
            ST_INC: begin
                if (is16_q && !second_q) begin
                    state_d  = ST_RD;
                    second_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_LD: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                err_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Push writes high byte first so the low byte lands at the lower address;
        // pop reads low byte first from the top of the stack.
        byte_sel_d = 1'b0;
        if (state_d == ST_WR) begin
            byte_sel_d = is16_d && !second_d;
        end else if (state_d == ST_RD) begin
            byte_sel_d = second_d;
        end

        busy_d      = (state_d != ST_IDLE);
        sp_cdownn_d = (state_d != ST_DEC);
        sp_cupn_d   = (state_d != ST_INC);
        sp_loadn_d  = (state_d != ST_LD);
        sp_outn_d   = !((state_d == ST_WR) || (state_d == ST_RD));
        mem_wen_d   = (state_d != ST_WR);
        mem_oen_d   = (state_d != ST_RD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            second_q    <= 1'b0;
            is16_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            byte_sel_q  <= 1'b0;
            sp_outn_q   <= 1'b1;
            sp_loadn_q  <= 1'b1;
            sp_cupn_q   <= 1'b1;
            sp_cdownn_q <= 1'b1;
            mem_oen_q   <= 1'b1;
            mem_wen_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            second_q    <= second_d;
            is16_q      <= is16_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            byte_sel_q  <= byte_sel_d;
            sp_outn_q   <= sp_outn_d;
            sp_loadn_q  <= sp_loadn_d;
            sp_cupn_q   <= sp_cupn_d;
            sp_cdownn_q <= sp_cdownn_d;
            mem_oen_q   <= mem_oen_d;
            mem_wen_q   <= mem_wen_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign byte_sel  = byte_sel_q;
    assign sp_outn   = sp_outn_q;
    assign sp_loadn  = sp_loadn_q;
    assign sp_cupn   = sp_cupn_q;
    assign sp_cdownn = sp_cdownn_q;
    assign mem_oen   = mem_oen_q;
    assign mem_wen   = mem_wen_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: walks push/pop/load sequences cycle by
// cycle and checks strobes, depth and flags against hand-derived values.
module tb_stack_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] cmd;
    logic       busy, done, err;
    logic       sp_outn, sp_loadn, sp_cupn, sp_cdownn, mem_oen, mem_wen;
    logic       byte_sel;
    logic [7:0] depth;
    logic [5:0] strobes;

    int checks   = 0;
    int failures = 0;

    // Strobe vector order: {sp_outn, sp_loadn, sp_cupn, sp_cdownn, mem_oen, mem_wen}
    localparam logic [5:0] S_NONE = 6'b111111;
    localparam logic [5:0] S_DEC  = 6'b111011;
    localparam logic [5:0] S_WR   = 6'b011110;
    localparam logic [5:0] S_RD   = 6'b011101;
    localparam logic [5:0] S_INC  = 6'b110111;
    localparam logic [5:0] S_LD   = 6'b101111;

    assign strobes = {sp_outn, sp_loadn, sp_cupn, sp_cdownn, mem_oen, mem_wen};

    stack_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cmd       (cmd),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .sp_outn   (sp_outn),
        .sp_loadn  (sp_loadn),
        .sp_cupn   (sp_cupn),
        .sp_cdownn (sp_cdownn),
        .mem_oen   (mem_oen),
        .mem_wen   (mem_wen),
        .byte_sel  (byte_sel),
        .depth     (depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs for the coming edge, then advance to 1 time unit past it.
    task automatic applyStimulus(input logic s, input logic [2:0] c);
        start = s;
        cmd   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag, input logic exp_done, input logic exp_err, input logic [7:0] exp_depth);
        checkOutput({tag, "_strobes"}, {2'b0, strobes}, {2'b0, S_NONE});
        checkOutput({tag, "_busy"}, {7'b0, busy}, 8'd0);
        checkOutput({tag, "_done"}, {7'b0, done}, {7'b0, exp_done});
        checkOutput({tag, "_err"}, {7'b0, err}, {7'b0, exp_err});
        checkOutput({tag, "_depth"}, depth, exp_depth);
    endtask

    task automatic checkActive(input string tag, input logic [5:0] exp_strobes, input logic exp_bs, input logic [7:0] exp_depth);
        checkOutput({tag, "_strobes"}, {2'b0, strobes}, {2'b0, exp_strobes});
        checkOutput({tag, "_busy"}, {7'b0, busy}, 8'd1);
        checkOutput({tag, "_done"}, {7'b0, done}, 8'd0);
        checkOutput({tag, "_bsel"}, {7'b0, byte_sel}, {7'b0, exp_bs});
        checkOutput({tag, "_depth"}, depth, exp_depth);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        cmd   = 3'b000;
        applyStimulus(1'b1, 3'b000);
        applyStimulus(1'b1, 3'b000);
        reset = 1'b0;
        checkIdle("reset", 1'b0, 1'b0, 8'd0);
        checkOutput("reset_bsel", {7'b0, byte_sel}, 8'd0);

        // PUSH8 from empty
        applyStimulus(1'b1, 3'b000);
        checkActive("push8_c1", S_DEC, 1'b0, 8'd0);
        applyStimulus(1'b0, 3'b000);
        checkActive("push8_c2", S_WR, 1'b0, 8'd1);
        applyStimulus(1'b0, 3'b000);
        checkIdle("push8_c3", 1'b1, 1'b0, 8'd1);

        // PUSH16 from depth 1, with start held high (cmd=LOAD) while busy
        applyStimulus(1'b1, 3'b010);
        checkActive("push16_c1", S_DEC, 1'b0, 8'd1);
        applyStimulus(1'b1, 3'b100);
        checkActive("push16_c2", S_WR, 1'b1, 8'd2);
        applyStimulus(1'b1, 3'b100);
        checkActive("push16_c3", S_DEC, 1'b0, 8'd2);
        applyStimulus(1'b1, 3'b100);
        checkActive("push16_c4", S_WR, 1'b0, 8'd3);
        applyStimulus(1'b0, 3'b100);
        checkIdle("push16_c5", 1'b1, 1'b0, 8'd3);
        applyStimulus(1'b0, 3'b000);
        checkIdle("push16_c6", 1'b0, 1'b0, 8'd3);

        // POP16 from depth 3
        applyStimulus(1'b1, 3'b011);
        checkActive("pop16_c1", S_RD, 1'b0, 8'd3);
        applyStimulus(1'b0, 3'b000);
        checkActive("pop16_c2", S_INC, 1'b0, 8'd3);
        applyStimulus(1'b0, 3'b000);
        checkActive("pop16_c3", S_RD, 1'b1, 8'd2);
        applyStimulus(1'b0, 3'b000);
        checkActive("pop16_c4", S_INC, 1'b0, 8'd2);
        applyStimulus(1'b0, 3'b000);
        checkIdle("pop16_c5", 1'b1, 1'b0, 8'd1);

        // POP16 at depth 1 is rejected
        applyStimulus(1'b1, 3'b011);
        checkIdle("pop16_rej", 1'b1, 1'b1, 8'd1);
        applyStimulus(1'b0, 3'b000);
        checkIdle("pop16_rej_after", 1'b0, 1'b1, 8'd1);

        // LOAD clears depth and err
        applyStimulus(1'b1, 3'b100);
        checkActive("load_c1", S_LD, 1'b0, 8'd1);
        checkOutput("load_c1_err", {7'b0, err}, 8'd1);
        applyStimulus(1'b0, 3'b000);
        checkIdle("load_c2", 1'b1, 1'b0, 8'd0);

        // Reset during the second DEC of PUSH16
        applyStimulus(1'b1, 3'b010);
        applyStimulus(1'b0, 3'b000);
        applyStimulus(1'b0, 3'b000);
        checkActive("abort_c3", S_DEC, 1'b0, 8'd1);
        reset = 1'b1;
        applyStimulus(1'b0, 3'b000);
        reset = 1'b0;
        checkIdle("abort_rst", 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 3'b000);
        checkIdle("abort_after", 1'b0, 1'b0, 8'd0);

        // Illegal command
        applyStimulus(1'b1, 3'b110);
        checkIdle("illegal", 1'b1, 1'b1, 8'd0);
        applyStimulus(1'b0, 3'b000);
        checkIdle("illegal_after", 1'b0, 1'b1, 8'd0);

        // POP8 on empty stack is rejected
        applyStimulus(1'b1, 3'b100);
        applyStimulus(1'b0, 3'b000);
        checkIdle("load2", 1'b1, 1'b0, 8'd0);
        applyStimulus(1'b1, 3'b001);
        checkIdle("pop8_empty", 1'b1, 1'b1, 8'd0);
        applyStimulus(1'b1, 3'b100);
        applyStimulus(1'b0, 3'b000);
        checkIdle("load3", 1'b1, 1'b0, 8'd0);

        // Fill to 253 with PUSH8
        for (int i = 0; i < 253; i++) begin
            applyStimulus(1'b1, 3'b000);
            applyStimulus(1'b0, 3'b000);
            applyStimulus(1'b0, 3'b000);
        end
        checkIdle("fill253", 1'b1, 1'b0, 8'd253);

        // PUSH16 at 253 is accepted and ends at 255
        applyStimulus(1'b1, 3'b010);
        checkActive("push16_253_c1", S_DEC, 1'b0, 8'd253);
        applyStimulus(1'b0, 3'b000);
        applyStimulus(1'b0, 3'b000);
        applyStimulus(1'b0, 3'b000);
        checkActive("push16_253_c4", S_WR, 1'b0, 8'd255);
        applyStimulus(1'b0, 3'b000);
        checkIdle("push16_253_c5", 1'b1, 1'b0, 8'd255);

        // PUSH8 at 255 is rejected
        applyStimulus(1'b1, 3'b000);
        checkIdle("push8_full", 1'b1, 1'b1, 8'd255);

        // POP8 to 254; err stays sticky across a successful pop
        applyStimulus(1'b1, 3'b001);
        checkActive("pop8_c1", S_RD, 1'b0, 8'd255);
        applyStimulus(1'b0, 3'b000);
        checkActive("pop8_c2", S_INC, 1'b0, 8'd255);
        applyStimulus(1'b0, 3'b000);
        checkIdle("pop8_c3", 1'b1, 1'b1, 8'd254);

        // PUSH16 at 254 would reach 256: rejected
        applyStimulus(1'b1, 3'b010);
        checkIdle("push16_254", 1'b1, 1'b1, 8'd254);
        applyStimulus(1'b0, 3'b000);
        checkIdle("push16_254_after", 1'b0, 1'b1, 8'd254);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
